// File: rtl/button_pkg.sv
// Shared defaults and types for the multi-channel button debouncer.
// BUTTON_AUTOREPEAT_EN selects the auto-repeat build of button_channel.
package button_pkg;

  localparam int unsigned TICK_DIV_DEFAULT     = 100000;
  localparam int unsigned STABLE_TICKS_DEFAULT = 20;
  localparam int unsigned REPEAT_DELAY_DEFAULT = 500;
  localparam int unsigned REPEAT_RATE_DEFAULT  = 100;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rptState_t;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One debounce channel: 2-FF synchroniser, tick-counted stability filter, press/release pulses.
// With BUTTON_AUTOREPEAT_EN defined, a held button also emits repeated press pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEFAULT
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEFAULT
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic button,
  output logic level,
  output logic press,
  output logic released
);

  localparam int unsigned STAB_W = $clog2(STABLE_TICKS + 1);

  logic              sync1;
  logic              sync2;
  logic [STAB_W-1:0] stabCnt;
  logic              accept;
  logic              pressNext;

  // A new level is taken on the tick that completes the run of differing samples.
  assign accept = tick && (sync2 != level) && (stabCnt == STAB_W'(STABLE_TICKS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stabCnt  <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      sync1    <= button;
      sync2    <= sync1;
      press    <= pressNext;
      released <= accept && !sync2;
      if (tick) begin
        if (sync2 == level) begin
          stabCnt <= '0;
        end else if (accept) begin
          level   <= sync2;
          stabCnt <= '0;
        end else begin
          stabCnt <= stabCnt + 1'b1;
        end
      end
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(maxOf(REPEAT_DELAY, REPEAT_RATE) + 1);

  rptState_t        rptState;
  logic [RPT_W-1:0] rptCnt;
  logic             rptFire;

  // accept while held means a release is being taken, which suppresses any repeat.
  always_comb begin
    rptFire = 1'b0;
    if (tick && !accept) begin
      unique case (rptState)
        DELAY:   rptFire = (rptCnt == RPT_W'(REPEAT_DELAY - 1));
        REPEAT:  rptFire = (rptCnt == RPT_W'(REPEAT_RATE - 1));
        default: rptFire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptState <= IDLE;
      rptCnt   <= '0;
    end else if (accept) begin
      rptState <= sync2 ? DELAY : IDLE;
      rptCnt   <= '0;
    end else if (tick && (rptState != IDLE)) begin
      if (rptFire) begin
        rptState <= REPEAT;
        rptCnt   <= '0;
      end else begin
        rptCnt <= rptCnt + 1'b1;
      end
    end
  end

  assign pressNext = (accept && sync2) || rptFire;
`else
  assign pressNext = accept && sync2;
`endif

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel button debouncer: shared tick prescaler feeding one button_channel per button.
// BUTTON_AUTOREPEAT_EN enables per-channel auto-repeat; `release` is reserved, so that output is `released`.
module multi_button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS  = 4,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic [NUM_BUTTONS-1:0] level,
  output logic [NUM_BUTTONS-1:0] press,
  output logic [NUM_BUTTONS-1:0] released,
  output logic                   tick
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  if (NUM_BUTTONS < 1) begin : gBadNum
    $error("NUM_BUTTONS must be >= 1");
  end
  if (TICK_DIV < 2) begin : gBadDiv
    $error("TICK_DIV must be >= 2");
  end
  if (STABLE_TICKS < 1) begin : gBadStable
    $error("STABLE_TICKS must be >= 1");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : gBadRepeat
    $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic [DIV_W-1:0] divCnt;

  assign tick = (divCnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
    end else begin
      divCnt <= tick ? '0 : divCnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gChan
    button_channel #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef BUTTON_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) uChan (
      .clock   (clock),
      .reset   (reset),
      .tick    (tick),
      .button  (button[i]),
      .level   (level[i]),
      .press   (press[i]),
      .released(released[i])
    );
  end

endmodule
